// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Asynchronous serial transmitter. One byte is accepted per send request in
//   idle and shifted out as: start bit (0), 8 data bits LSB first, optional
//   parity bit, then 1 or 2 stop bits (1). Every bit lasts CLKS_PER_BIT clocks.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   send  in   transmit request, level sensitive while idle
//   data  in   byte to send, captured when send is accepted
//   busy  out  high for the whole frame
//   tx    out  serial line, idle high (driven straight from a flop)
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    if (CLKS_PER_BIT < 2) begin : gen_bad_clks
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY > 2) begin : gen_bad_parity
        $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam int unsigned DivW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q;
    logic [DivW-1:0] div_q;       // cycles left in the current bit, minus one
    logic [2:0]      bit_idx_q;   // data bit currently on the line
    logic [7:0]      shreg_q;     // remaining data bits, next one at [0]
    logic            par_q;       // parity bit, computed once at acceptance
    logic            stop_idx_q;  // which stop bit is on the line
    logic            tx_q;
    logic            busy_q;

    assign tx   = tx_q;
    assign busy = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (send) begin
                        shreg_q <= data;
                        // Odd parity sets the bit when the data has an even
                        // number of ones; even parity copies the data's XOR.
                        par_q   <= (PARITY == 1) ? ~(^data) : ^data;
                        div_q   <= DivMax;
                        state_q <= StStart;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end

                StStart: begin
                    if (div_q == '0) begin
                        div_q     <= DivMax;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        state_q   <= StData;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end

                StData: begin
                    if (div_q == '0) begin
                        div_q <= DivMax;
                        if (bit_idx_q == 3'd7) begin
                            if (PARITY != 0) begin
                                tx_q    <= par_q;
                                state_q <= StParity;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_idx_q <= 1'b0;
                                state_q    <= StStop;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end

                StParity: begin
                    if (div_q == '0) begin
                        div_q      <= DivMax;
                        tx_q       <= 1'b1;
                        stop_idx_q <= 1'b0;
                        state_q    <= StStop;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end

                StStop: begin
                    if (div_q == '0) begin
                        div_q <= DivMax;
                        if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                            // Frame ends here; send is only looked at from
                            // the following idle cycle, giving a 1-cycle gap.
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer. Three instances run side by side:
//   0: defaults (no parity, 1 stop), 1: even parity, 2 stop, 2: odd parity, 1 stop.
// A frame-level model predicts tx/busy every cycle; directed literals pin it.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_v [3];
    logic [7:0] data_v [3];
    logic       tx_w   [3];
    logic       busy_w [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .send(send_v[0]), .data(data_v[0]),
        .busy(busy_w[0]), .tx(tx_w[0])
    );
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .send(send_v[1]), .data(data_v[1]),
        .busy(busy_w[1]), .tx(tx_w[1])
    );
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .send(send_v[2]), .data(data_v[2]),
        .busy(busy_w[2]), .tx(tx_w[2])
    );

    int cfg_par  [3] = '{0, 2, 1};
    int cfg_stop [3] = '{1, 2, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as a bit list, index 0 first on the line; unused tail stays 1.
    function automatic logic [11:0] frame_bits(input int par, input logic [7:0] d);
        logic [11:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        for (int b = 0; b < 8; b++) f[1 + b] = d[b];
        ones = $countones(d);
        if (par == 1) f[9] = (ones % 2 == 0);
        if (par == 2) f[9] = (ones % 2 == 1);
        return f;
    endfunction

    // Model: position within the current frame in clock cycles, -1 when idle.
    int          m_pos  [3] = '{-1, -1, -1};
    int          m_len  [3] = '{10, 10, 10};
    logic [11:0] m_bits [3];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_pos[i] <= -1;
            end else if (m_pos[i] < 0) begin
                if (send_v[i] === 1'b1) begin
                    m_bits[i] <= frame_bits(cfg_par[i], data_v[i]);
                    m_len[i]  <= 9 + (cfg_par[i] != 0 ? 1 : 0) + cfg_stop[i];
                    m_pos[i]  <= 0;
                end
            end else if (m_pos[i] == m_len[i] * CPB - 1) begin
                m_pos[i] <= -1;
            end else begin
                m_pos[i] <= m_pos[i] + 1;
            end
        end
    end

    logic [11:0] cmp_bits;
    logic        exp_tx;
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            cmp_bits = m_bits[i];
            exp_tx   = (m_pos[i] < 0) ? 1'b1 : cmp_bits[m_pos[i] / CPB];
            chk($sformatf("model_tx[%0d]", i), 32'(tx_w[i]), 32'(exp_tx));
            chk($sformatf("model_busy[%0d]", i), 32'(busy_w[i]), 32'(m_pos[i] >= 0));
        end
    end

    // Per-instance results of measure(): mid-bit tx samples and busy-cycle count.
    logic [11:0] cap  [3];
    int          bcnt [3];

    task automatic start_all(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        data_v[0] = d0;
        data_v[1] = d1;
        data_v[2] = d2;
        for (int i = 0; i < 3; i++) send_v[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) send_v[i] = 1'b0;
    endtask

    // Runs ncyc cycles from the first frame cycle; optionally pulses send on
    // instance 0 with 0xFF at cycle pulse_cyc.
    task automatic measure(input int ncyc, input int pulse_cyc);
        for (int i = 0; i < 3; i++) begin
            cap[i]  = '1;
            bcnt[i] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (busy_w[i] === 1'b1) bcnt[i]++;
                if (c % CPB == 1 && c / CPB < 12) cap[i][c / CPB] = tx_w[i];
            end
            if (c == pulse_cyc) begin
                send_v[0] = 1'b1;
                data_v[0] = 8'hFF;
            end else if (c == pulse_cyc + 1) begin
                send_v[0] = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    logic [11:0] f1;
    logic [11:0] f2;
    int          idle_cnt;
    int          first_idle;

    initial begin
        for (int i = 0; i < 3; i++) begin
            send_v[i] = 1'b0;
            data_v[i] = 8'h00;
        end

        // Reset values
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_tx[%0d]", i), 32'(tx_w[i]), 32'd1);
            chk($sformatf("reset_busy[%0d]", i), 32'(busy_w[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 0x55 on defaults with an ignored send mid-frame; 0x07 with parity.
        start_all(8'h55, 8'h07, 8'h07);
        measure(60, 10);
        chk("u55_bits", 32'(cap[0][9:0]), 32'(10'b1010101010));
        chk("u55_busy_cycles", bcnt[0], 32'd40);
        chk("even2_bits", 32'(cap[1]), 32'(12'b111000001110));
        chk("even2_busy_cycles", bcnt[1], 32'd48);
        chk("odd_bits", 32'(cap[2][10:0]), 32'(11'b10000001110));
        chk("odd_busy_cycles", bcnt[2], 32'd44);

        // Back-to-back 0xA5 with send held high
        data_v[0] = 8'hA5;
        send_v[0] = 1'b1;
        @(negedge clk);
        f1         = '1;
        f2         = '1;
        idle_cnt   = 0;
        first_idle = -1;
        for (int c = 0; c < 123; c++) begin
            if (busy_w[0] === 1'b0) begin
                idle_cnt++;
                if (first_idle < 0) first_idle = c;
            end
            if (c < 40 && c % CPB == 1) f1[c / CPB] = tx_w[0];
            if (c >= 41 && c < 81 && (c - 41) % CPB == 1) f2[(c - 41) / CPB] = tx_w[0];
            if (c == 122) send_v[0] = 1'b0;
            @(negedge clk);
        end
        chk("b2b_frame1", 32'(f1[9:0]), 32'(10'b1101001010));
        chk("b2b_frame2", 32'(f2[9:0]), 32'(10'b1101001010));
        chk("b2b_idle_cycles", idle_cnt, 32'd3);
        chk("b2b_first_gap", first_idle, 32'd40);
        repeat (45) @(negedge clk);
        chk("b2b_stopped", 32'(busy_w[0]), 32'd0);

        // Reset in the middle of the data bits; outputs clear before the next edge
        start_all(8'h00, 8'h00, 8'h00);
        repeat (15) @(negedge clk);
        chk("pre_reset_busy", 32'(busy_w[0]), 32'd1);
        chk("pre_reset_tx", 32'(tx_w[0]), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_rst_tx[%0d]", i), 32'(tx_w[i]), 32'd1);
            chk($sformatf("async_rst_busy[%0d]", i), 32'(busy_w[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        start_all(8'h3C, 8'h3C, 8'h3C);
        measure(60, -5);
        chk("post_rst_bits", 32'(cap[0][9:0]), 32'(10'b1001111000));
        chk("post_rst_busy", bcnt[0], 32'd40);
        chk("post_rst_even_bits", 32'(cap[1]), 32'(12'b110001111000));
        chk("post_rst_odd_bits", 32'(cap[2][10:0]), 32'(11'b11001111000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
